// File: rtl/timer_mode_ctrl.sv
// Mode/scheduler controller for the HH:mm:ss timer: user mode FSM, set-time strobes,
// alarm register with ring timer, and the chime/alarm tone select.
module timer_mode_ctrl #(
  parameter int TIMEOUT_S = 10,
  parameter int ALARM_S   = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       alarm_en,
  input  logic [3:0] h1,
  input  logic [3:0] h2,
  input  logic [3:0] m1,
  input  logic [3:0] m2,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  output logic       run_en,
  output logic       inc_min,
  output logic       inc_hour,
  output logic [2:0] mode,
  output logic [3:0] alm_h1,
  output logic [3:0] alm_h2,
  output logic [3:0] alm_m1,
  output logic [3:0] alm_m2,
  output logic       ringing,
  output logic [1:0] bee_in
);

  // state        | meaning
  // RUN          | time free-runs, alarm may ring, btn_inc dismisses
  // SET_MIN      | seconds held, btn_inc strobes inc_min
  // SET_HOUR     | seconds held, btn_inc strobes inc_hour
  // SET_ALM_MIN  | time runs, btn_inc bumps alarm minute
  // SET_ALM_HOUR | time runs, btn_inc bumps alarm hour
  localparam logic [2:0] RUN          = 3'd0;
  localparam logic [2:0] SET_MIN      = 3'd1;
  localparam logic [2:0] SET_HOUR     = 3'd2;
  localparam logic [2:0] SET_ALM_MIN  = 3'd3;
  localparam logic [2:0] SET_ALM_HOUR = 3'd4;

  localparam int TMO_W = $clog2(TIMEOUT_S + 1);
  localparam int ACN_W = $clog2(ALARM_S + 1);

  logic [2:0]       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             inc_min_q, inc_min_d;
  logic             inc_hour_q, inc_hour_d;
  logic [3:0]       alm_h1_q, alm_h1_d, alm_h2_q, alm_h2_d;
  logic [3:0]       alm_m1_q, alm_m1_d, alm_m2_q, alm_m2_d;
  logic             tick_q;
  logic             ring_q, ring_d;
  logic [ACN_W-1:0] acnt_q, acnt_d;
  logic [1:0]       bee_q, bee_d;

  logic in_set, tmo_hit, inc_en, match, ring_clr;
  logic chime_pre, chime_top;

  assign in_set  = (state_q != RUN);
  assign tmo_hit = in_set && tick_1hz && (tmo_q == TMO_W'(TIMEOUT_S - 1));
  assign inc_en  = btn_inc && !btn_mode;

  always_comb begin
    state_d = state_q;
    // timeout outranks btn_mode so a coincident press still lands in RUN exactly once
    if (tmo_hit) begin
      state_d = RUN;
    end else if (btn_mode) begin
      case (state_q)
        RUN:          state_d = SET_MIN;
        SET_MIN:      state_d = SET_HOUR;
        SET_HOUR:     state_d = SET_ALM_MIN;
        SET_ALM_MIN:  state_d = SET_ALM_HOUR;
        default:      state_d = RUN;
      endcase
    end
  end

  always_comb begin
    tmo_d = tmo_q;
    if ((state_d != state_q) || !in_set || btn_mode || btn_inc) begin
      tmo_d = '0;
    end else if (tick_1hz) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  assign inc_min_d  = (state_q == SET_MIN)  && inc_en;
  assign inc_hour_d = (state_q == SET_HOUR) && inc_en;

  always_comb begin
    alm_m1_d = alm_m1_q;
    alm_m2_d = alm_m2_q;
    alm_h1_d = alm_h1_q;
    alm_h2_d = alm_h2_q;
    if ((state_q == SET_ALM_MIN) && inc_en) begin
      if (alm_m2_q == 4'd9) begin
        alm_m2_d = 4'd0;
        alm_m1_d = (alm_m1_q == 4'd5) ? 4'd0 : alm_m1_q + 4'd1;
      end else begin
        alm_m2_d = alm_m2_q + 4'd1;
      end
    end
    if ((state_q == SET_ALM_HOUR) && inc_en) begin
      if ((alm_h1_q == 4'd2) && (alm_h2_q == 4'd3)) begin
        alm_h1_d = 4'd0;
        alm_h2_d = 4'd0;
      end else if (alm_h2_q == 4'd9) begin
        alm_h1_d = alm_h1_q + 4'd1;
        alm_h2_d = 4'd0;
      end else begin
        alm_h2_d = alm_h2_q + 4'd1;
      end
    end
  end

  // Compare one cycle after the tick so the digits seen are the post-tick time.
  assign match = (state_q == RUN) && alarm_en && tick_q &&
                 (h1 == alm_h1_q) && (h2 == alm_h2_q) &&
                 (m1 == alm_m1_q) && (m2 == alm_m2_q) &&
                 (s1 == 4'd0) && (s2 == 4'd0);

  assign ring_clr = ((state_q == RUN) && btn_inc) || !alarm_en || (state_d != RUN);

  always_comb begin
    ring_d = ring_q;
    acnt_d = acnt_q;
    if (ring_clr) begin
      ring_d = 1'b0;
      acnt_d = '0;
    end else if (!ring_q && match) begin
      ring_d = 1'b1;
      acnt_d = ACN_W'(ALARM_S);
    end else if (ring_q && tick_q) begin
      if (acnt_q <= ACN_W'(1)) begin
        ring_d = 1'b0;
        acnt_d = '0;
      end else begin
        acnt_d = acnt_q - 1'b1;
      end
    end
  end

  assign chime_pre = (m1 == 4'd5) && (m2 == 4'd9) && (s1 == 4'd5) &&
                     (s2 <= 4'd8) && !s2[0];
  assign chime_top = (m1 == 4'd0) && (m2 == 4'd0) && (s1 == 4'd0) && (s2 == 4'd0);

  always_comb begin
    bee_d = 2'b00;
    if (chime_pre) begin
      bee_d = 2'b01;
    end else if (chime_top) begin
      bee_d = 2'b10;
    end else if (ring_q && !s2[0]) begin
      bee_d = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      tmo_q      <= '0;
      inc_min_q  <= 1'b0;
      inc_hour_q <= 1'b0;
      alm_h1_q   <= 4'd0;
      alm_h2_q   <= 4'd0;
      alm_m1_q   <= 4'd0;
      alm_m2_q   <= 4'd0;
      tick_q     <= 1'b0;
      ring_q     <= 1'b0;
      acnt_q     <= '0;
      bee_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      inc_min_q  <= inc_min_d;
      inc_hour_q <= inc_hour_d;
      alm_h1_q   <= alm_h1_d;
      alm_h2_q   <= alm_h2_d;
      alm_m1_q   <= alm_m1_d;
      alm_m2_q   <= alm_m2_d;
      tick_q     <= tick_1hz;
      ring_q     <= ring_d;
      acnt_q     <= acnt_d;
      bee_q      <= bee_d;
    end
  end

  assign run_en   = !((state_q == SET_MIN) || (state_q == SET_HOUR));
  assign inc_min  = inc_min_q;
  assign inc_hour = inc_hour_q;
  assign mode     = state_q;
  assign alm_h1   = alm_h1_q;
  assign alm_h2   = alm_h2_q;
  assign alm_m1   = alm_m1_q;
  assign alm_m2   = alm_m2_q;
  assign ringing  = ring_q;
  assign bee_in   = bee_q;

endmodule

// File: tb/tb_timer_mode_ctrl.sv
// Directed bench for timer_mode_ctrl: mode walk, field setting, timeout, chime and alarm.
module tb_timer_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       alarm_en = 1'b0;
  logic [3:0] h1 = 4'd0, h2 = 4'd0, m1 = 4'd0, m2 = 4'd0, s1 = 4'd0, s2 = 4'd0;
  logic       run_en, inc_min, inc_hour, ringing;
  logic [2:0] mode;
  logic [3:0] alm_h1, alm_h2, alm_m1, alm_m2;
  logic [1:0] bee_in;

  int n_chk = 0;
  int n_pass = 0;
  int n_min = 0;
  int n_hour = 0;
  int base_min, base_hour;

  timer_mode_ctrl dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .alarm_en(alarm_en), .h1(h1), .h2(h2), .m1(m1), .m2(m2), .s1(s1), .s2(s2),
    .run_en(run_en), .inc_min(inc_min), .inc_hour(inc_hour), .mode(mode),
    .alm_h1(alm_h1), .alm_h2(alm_h2), .alm_m1(alm_m1), .alm_m2(alm_m2),
    .ringing(ringing), .bee_in(bee_in)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inc_min === 1'b1) n_min <= n_min + 1;
    if (inc_hour === 1'b1) n_hour <= n_hour + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    step();
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    step();
    btn_inc = 1'b0;
    step();
  endtask

  task automatic set_time(input int hh, input int mm, input int ss);
    h1 = 4'(hh / 10); h2 = 4'(hh % 10);
    m1 = 4'(mm / 10); m2 = 4'(mm % 10);
    s1 = 4'(ss / 10); s2 = 4'(ss % 10);
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  initial begin
    // reset values
    #2 rst = 1'b1;
    #1;
    chk("rst_mode", int'(mode), 0);
    chk("rst_run_en", int'(run_en), 1);
    chk("rst_bee", int'(bee_in), 0);
    chk("rst_ring", int'(ringing), 0);
    chk("rst_alm", int'({alm_h1, alm_h2, alm_m1, alm_m2}), 0);
    step(2);
    rst = 1'b0;
    step();

    // mode walk
    press_mode(); chk("walk_mode1", int'(mode), 1); chk("walk_run1", int'(run_en), 0);
    press_mode(); chk("walk_mode2", int'(mode), 2); chk("walk_run2", int'(run_en), 0);
    press_mode(); chk("walk_mode3", int'(mode), 3); chk("walk_run3", int'(run_en), 1);
    press_mode(); chk("walk_mode4", int'(mode), 4); chk("walk_run4", int'(run_en), 1);
    press_mode(); chk("walk_mode0", int'(mode), 0); chk("walk_run0", int'(run_en), 1);
    press_mode();
    base_min = n_min;
    btn_mode = 1'b1; btn_inc = 1'b1;
    step();
    btn_mode = 1'b0; btn_inc = 1'b0;
    step(2);
    chk("both_mode", int'(mode), 2);
    chk("both_no_inc_min", n_min - base_min, 0);
    press_mode(); press_mode(); press_mode();
    chk("walk_back_run", int'(mode), 0);

    // alarm field setting
    press_mode(); press_mode(); press_mode();
    chk("alm_min_state", int'(mode), 3);
    repeat (59) press_inc();
    chk("alm_m_59", int'({alm_m1, alm_m2}), 8'h59);
    press_inc();
    chk("alm_m_wrap", int'({alm_m1, alm_m2}), 8'h00);
    press_inc();
    chk("alm_m_61", int'({alm_m1, alm_m2}), 8'h01);
    chk("alm_h_untouched", int'({alm_h1, alm_h2}), 8'h00);
    press_mode();
    repeat (23) press_inc();
    chk("alm_h_23", int'({alm_h1, alm_h2}), 8'h23);
    press_inc();
    chk("alm_h_wrap", int'({alm_h1, alm_h2}), 8'h00);
    press_inc();
    chk("alm_h_25", int'({alm_h1, alm_h2}), 8'h01);
    press_mode();
    chk("alm_back_run", int'(mode), 0);

    // time setting strobes
    press_mode();
    base_min = n_min; base_hour = n_hour;
    press_inc();
    chk("inc_min_cnt", n_min - base_min, 1);
    chk("inc_min_no_hour", n_hour - base_hour, 0);
    press_mode();
    base_min = n_min; base_hour = n_hour;
    press_inc();
    chk("inc_hour_cnt", n_hour - base_hour, 1);
    chk("inc_hour_no_min", n_min - base_min, 0);

    // timeout in SET_HOUR
    repeat (9) tick();
    step();
    chk("tmo_9_hold", int'(mode), 2);
    press_inc();
    repeat (9) tick();
    step();
    chk("tmo_restart", int'(mode), 2);
    tick();
    step();
    chk("tmo_10_run", int'(mode), 0);
    chk("tmo_run_en", int'(run_en), 1);

    // hourly chime
    for (int s = 50; s <= 59; s++) begin
      set_time(0, 59, s);
      step(2);
      chk($sformatf("chime_00:59:%0d", s), int'(bee_in), (s % 2 == 0) ? 1 : 0);
    end
    set_time(1, 0, 0);  step(2); chk("chime_top", int'(bee_in), 2);
    set_time(0, 58, 50); step(2); chk("chime_mm58", int'(bee_in), 0);
    set_time(12, 30, 0); step(2); chk("chime_mm30", int'(bee_in), 0);

    // set alarm to 07:30
    press_mode(); press_mode(); press_mode();
    repeat (29) press_inc();
    press_mode();
    repeat (6) press_inc();
    press_mode();
    chk("alm_0730", int'({alm_h1, alm_h2, alm_m1, alm_m2}), 16'h0730);
    alarm_en = 1'b1;
    set_time(7, 29, 59); tick(); step(3);
    chk("alm_pre_ring", int'(ringing), 0);
    set_time(7, 30, 0); tick(); step(3);
    chk("alm_ring", int'(ringing), 1);
    chk("alm_bee_s00", int'(bee_in), 2);
    set_time(7, 30, 1); tick(); step(3);
    chk("alm_bee_s01", int'(bee_in), 0);
    chk("alm_ring_s01", int'(ringing), 1);
    set_time(7, 30, 2); tick(); step(3);
    chk("alm_bee_s02", int'(bee_in), 2);
    set_time(7, 30, 3); tick(); step();
    set_time(7, 30, 4); tick(); step();
    set_time(7, 30, 5); tick(); step();
    press_inc();
    step();
    chk("alm_dismiss", int'(ringing), 0);
    chk("alm_dismiss_bee", int'(bee_in), 0);
    set_time(7, 30, 6); tick(); step(3);
    chk("alm_dismiss_s06", int'(bee_in), 0);

    // undismissed ring expires after 30 ticks
    set_time(7, 30, 0); tick(); step(3);
    chk("ring2_start", int'(ringing), 1);
    for (int s = 1; s <= 29; s++) begin
      set_time(7, 30, s); tick(); step();
    end
    step(2);
    chk("ring2_29", int'(ringing), 1);
    set_time(7, 30, 30); tick(); step(3);
    chk("ring2_30", int'(ringing), 0);

    // alarm_en drop and leaving RUN both clear the ring
    set_time(7, 30, 0); tick(); step(3);
    chk("ring3_start", int'(ringing), 1);
    alarm_en = 1'b0; step(2);
    chk("ring3_en_drop", int'(ringing), 0);
    alarm_en = 1'b1;
    set_time(7, 30, 1); tick(); step();
    set_time(7, 30, 0); tick(); step(3);
    chk("ring4_start", int'(ringing), 1);
    press_mode();
    chk("ring4_mode", int'(mode), 1);
    chk("ring4_leave", int'(ringing), 0);

    // async reset mid-cycle while in SET_MIN with alarm 07:30
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_mode", int'(mode), 0);
    chk("arst_run_en", int'(run_en), 1);
    chk("arst_alm", int'({alm_h1, alm_h2, alm_m1, alm_m2}), 0);
    chk("arst_bee", int'(bee_in), 0);
    chk("arst_inc", int'({inc_min, inc_hour}), 0);
    step();
    rst = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
